// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
// Decodes the instruction from IF/ID, reads the register file, flags load-use
// hazards and registers the decoded result into the ID/EX pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_i,
  input  logic [31:0] ins_addr_i,
  input  logic        jump_flag,
  input  logic        hold_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        hold_o,
  output logic [31:0] ex_ins_o,
  output logic [31:0] ex_ins_addr_o,
  output logic [31:0] ex_imm_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_rd_we_o,
  output logic        ex_illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0,x0,0 -- the bubble that fills ID/EX on reset, flush and hazard
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        legal;
  logic        writes_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] imm;
  logic        rd_we;
  logic        ex_is_load;
  logic        hazard;

  assign opcode     = ins_i[6:0];
  assign rd         = ins_i[11:7];
  assign rs1_addr_o = ins_i[19:15];
  assign rs2_addr_o = ins_i[24:20];

  // Opcode decode: legality, immediate format, and which operands are used
  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    imm       = 32'h0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        imm       = {ins_i[31:12], 12'h000};
      end
      OPC_JAL: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        imm       = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        imm       = {{20{ins_i[31]}}, ins_i[31:20]};
      end
      OPC_SYSTEM: begin
        legal   = 1'b1;
        use_rs1 = 1'b1;
        imm     = {{20{ins_i[31]}}, ins_i[31:20]};
      end
      OPC_STORE: begin
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      end
      OPC_BRANCH: begin
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      end
      OPC_OP: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OPC_MISC: begin
        legal   = 1'b1;
        use_rs1 = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Writes to x0 are discarded at decode so EX never sees a live x0 write
  assign rd_we = writes_rd & (rd != 5'd0);

  // A load to x0 never stalls; only operands the opcode really reads count
  assign ex_is_load = (ex_ins_o[6:0] == OPC_LOAD) & (ex_rd_o != 5'd0);
  assign hazard     = ex_is_load &
                      ((use_rs1 & (rs1_addr_o == ex_rd_o)) |
                       (use_rs2 & (rs2_addr_o == ex_rd_o)));

  // A taken jump squashes this instruction anyway, so no hold is needed
  assign hold_o = hazard & ~jump_flag;

  // ID/EX register: reset > flush > external hold > hazard bubble > load
  always_ff @(posedge clk) begin
    if (rst || jump_flag || (!hold_i && hazard)) begin
      ex_ins_o      <= NOP_INS;
      ex_ins_addr_o <= 32'h0;
      ex_imm_o      <= 32'h0;
      ex_rs1_data_o <= 32'h0;
      ex_rs2_data_o <= 32'h0;
      ex_rd_o       <= 5'd0;
      ex_rd_we_o    <= 1'b0;
      ex_illegal_o  <= 1'b0;
    end else if (!hold_i) begin
      ex_ins_o      <= ins_i;
      ex_ins_addr_o <= ins_addr_i;
      ex_imm_o      <= imm;
      ex_rs1_data_o <= rs1_data_i;
      ex_rs2_data_o <= rs2_data_i;
      ex_rd_o       <= rd;
      ex_rd_we_o    <= rd_we;
      ex_illegal_o  <= ~legal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: each step drives one cycle of inputs, pushes
// the expected ID/EX contents to a queue and compares after the clock edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_i;
  logic [31:0] ins_addr_i;
  logic        jump_flag;
  logic        hold_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        hold_o;
  logic [31:0] ex_ins_o;
  logic [31:0] ex_ins_addr_o;
  logic [31:0] ex_imm_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [4:0]  ex_rd_o;
  logic        ex_rd_we_o;
  logic        ex_illegal_o;

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ins_i         (ins_i),
    .ins_addr_i    (ins_addr_i),
    .jump_flag     (jump_flag),
    .hold_i        (hold_i),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .hold_o        (hold_o),
    .ex_ins_o      (ex_ins_o),
    .ex_ins_addr_o (ex_ins_addr_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_rd_o       (ex_rd_o),
    .ex_rd_we_o    (ex_rd_we_o),
    .ex_illegal_o  (ex_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] addr;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } ex_t;

  localparam int DEC  = 0;
  localparam int BUB  = 1;
  localparam int KEEP = 2;

  ex_t sb[$];
  ex_t last;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs, push expectation,
  // clock, then pop and compare the registered ID/EX contents.
  task automatic step(input logic [31:0] ins, input logic [31:0] addr,
                      input logic jmp, input logic hld, input logic rs,
                      input logic exp_hold, input int kind,
                      input logic [31:0] imm, input logic [4:0] rd,
                      input logic we, input logic ill);
    ex_t e;
    ex_t got;
    ins_i      = ins;
    ins_addr_i = addr;
    jump_flag  = jmp;
    hold_i     = hld;
    rst        = rs;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    #1;
    if (exp_hold !== 1'bx) chk("hold_o", {31'b0, hold_o}, {31'b0, exp_hold});
    chk("rs1_addr", {27'b0, rs1_addr_o}, {27'b0, ins[19:15]});
    chk("rs2_addr", {27'b0, rs2_addr_o}, {27'b0, ins[24:20]});
    if (kind == DEC) begin
      e.ins = ins;  e.addr = addr; e.imm = imm;
      e.r1 = rs1_data_i; e.r2 = rs2_data_i;
      e.rd = rd; e.we = we; e.ill = ill;
    end else if (kind == BUB) begin
      e.ins = 32'h0000_0013; e.addr = 32'h0; e.imm = 32'h0;
      e.r1 = 32'h0; e.r2 = 32'h0; e.rd = 5'd0; e.we = 1'b0; e.ill = 1'b0;
    end else begin
      e = last;
    end
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("ex_ins",      ex_ins_o,                 got.ins);
    chk("ex_ins_addr", ex_ins_addr_o,            got.addr);
    chk("ex_imm",      ex_imm_o,                 got.imm);
    chk("ex_rs1_data", ex_rs1_data_o,            got.r1);
    chk("ex_rs2_data", ex_rs2_data_o,            got.r2);
    chk("ex_rd",       {27'b0, ex_rd_o},         {27'b0, got.rd});
    chk("ex_rd_we",    {31'b0, ex_rd_we_o},      {31'b0, got.we});
    chk("ex_illegal",  {31'b0, ex_illegal_o},    {31'b0, got.ill});
  endtask

  initial begin
    // reset for two cycles with junk on the inputs
    step(32'h1234_5678, 32'hdead_beef, 1'b0, 1'b0, 1'b1, 1'bx, BUB, 0, 0, 0, 0);
    step(32'h0000_A103, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, BUB, 0, 0, 0, 0);

    // addi x1,x0,5
    step(32'h0050_0093, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h5, 5'd1, 1'b1, 1'b0);
    // lw x2,0(x1) then add x3,x2,x1: one hold cycle with a bubble
    step(32'h0000_A103, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd2, 1'b1, 1'b0);
    step(32'h0011_01B3, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, BUB, 0, 0, 0, 0);
    step(32'h0011_01B3, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd3, 1'b1, 1'b0);
    // lw x0 followed by a reader of x0: no hold
    step(32'h0000_A003, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd0, 1'b0, 1'b0);
    step(32'h0000_01B3, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd3, 1'b1, 1'b0);
    // beq x1,x2,-8, then same with a taken jump
    step(32'hFE20_8CE3, 32'h18, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'hFFFF_FFF8, 5'd25, 1'b0, 1'b0);
    step(32'hFE20_8CE3, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 0, 0, 0, 0);
    // illegal opcode
    step(32'h0000_007F, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd0, 1'b0, 1'b1);
    // other formats: S, J, negative I, U
    step(32'h0020_A223, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h4, 5'd4, 1'b0, 1'b0);
    step(32'h0080_00EF, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h8, 5'd1, 1'b1, 1'b0);
    step(32'hFFF0_8093, 32'h28, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    // external hold for three cycles with changing ins_i, then release
    step(32'h0000_A103, 32'h2C, 1'b0, 1'b1, 1'b0, 1'b0, KEEP, 0, 0, 0, 0);
    step(32'h0000_007F, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0, KEEP, 0, 0, 0, 0);
    step(32'h0050_0093, 32'h34, 1'b0, 1'b1, 1'b0, 1'b0, KEEP, 0, 0, 0, 0);
    step(32'h1234_52B7, 32'h38, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h1234_5000, 5'd5, 1'b1, 1'b0);
    // lw x4 then add x5,x4,x0 under hold_i: frozen, then bubble, then load
    step(32'h0000_A203, 32'h3C, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd4, 1'b1, 1'b0);
    step(32'h0002_02B3, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, KEEP, 0, 0, 0, 0);
    step(32'h0002_02B3, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, BUB, 0, 0, 0, 0);
    step(32'h0002_02B3, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd5, 1'b1, 1'b0);
    // store reading the load result through rs2 only
    step(32'h0000_A103, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd2, 1'b1, 1'b0);
    step(32'h0020_0223, 32'h48, 1'b0, 1'b0, 1'b0, 1'b1, BUB, 0, 0, 0, 0);
    step(32'h0020_0223, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h4, 5'd4, 1'b0, 1'b0);
    // hazard with taken jump: no hold request, bubble loaded
    step(32'h0000_A203, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd4, 1'b1, 1'b0);
    step(32'h0002_02B3, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 0, 0, 0, 0);
    // reset mid-stream with hold_i set during a live hazard
    step(32'h0000_A203, 32'h54, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd4, 1'b1, 1'b0);
    step(32'h0002_02B3, 32'h58, 1'b0, 1'b1, 1'b1, 1'b1, BUB, 0, 0, 0, 0);
    step(32'h0002_02B3, 32'h58, 1'b0, 1'b0, 1'b0, 1'b0, DEC, 32'h0, 5'd5, 1'b1, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
